// File: rtl/rat_pkg.sv
// Shared return-address-stack constants and types.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rat_pkg;

    // Program-counter width; return addresses are the same width.
    localparam int PC_W = 10;

    // Default number of return-address entries.
    localparam int RS_DEPTH = 16;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/return_stack_if.sv
// Bundle of the return-stack control strobes and status outputs.
// Latency: none (wiring only).
// Backpressure: none; full/empty and the sticky error flags report dropped requests.
interface return_stack_if import rat_pkg::*; #(
    parameter int DEPTH = RS_DEPTH,
    parameter int AW    = PC_W
);
    logic [AW-1:0]            pc_count;
    logic                     push;
    logic                     pop;
    logic                     flush;
    logic                     clr_err;
    logic [AW-1:0]            from_stack;
    logic [$clog2(DEPTH):0]   sp;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;

    // Sequencer / PC logic side.
    modport master (
        output pc_count, push, pop, flush, clr_err,
        input  from_stack, sp, empty, full, overflow, underflow
    );

    // Return-stack side.
    modport slave (
        input  pc_count, push, pop, flush, clr_err,
        output from_stack, sp, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_regfile.sv
// DEPTH x AW entry storage: one synchronous write port, one asynchronous read port.
// Latency: write lands at the next edge; read is combinational.
// Backpressure: none; caller decides which writes are accepted.
module stack_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [AW-1:0]            rdata
);
    logic [AW-1:0] mem [DEPTH];

    // Entries are deliberately not reset; they are invisible while the stack is empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/return_stack.sv
// Hardware CALL/RET return-address stack with sticky overflow/underflow flags.
// Latency: top-of-stack read is combinational; push/pop/flush take effect at the next edge.
// Backpressure: none; pushes when full and pops when empty are dropped and flagged.
module return_stack import rat_pkg::*; #(
    parameter int DEPTH = RS_DEPTH,
    parameter int AW    = PC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    return_stack_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = IW + 1;

    logic [SW-1:0] sp_q;
    logic          overflow_q;
    logic          underflow_q;

    logic          is_empty;
    logic          is_full;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] push_idx;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] top_data;

    logic          push_only;
    logic          pop_only;
    logic          replace;
    logic          push_ok;
    logic          push_drop;
    logic          pop_ok;
    logic          pop_drop;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SW'(DEPTH));

    // sp-1 wraps harmlessly when empty; the read result is masked in that case.
    assign top_idx  = IW'(sp_q - SW'(1));
    assign push_idx = sp_q[IW-1:0];

    // Return address wraps naturally at 2^AW.
    assign ret_addr = bus.pc_count + AW'(1);

    // A CALL+RET pair on an empty stack degenerates to a plain CALL.
    assign push_only = bus.push & (~bus.pop | is_empty);
    assign pop_only  = bus.pop & ~bus.push;
    assign replace   = ~bus.flush & bus.push & bus.pop & ~is_empty;

    assign push_ok   = ~bus.flush & push_only & ~is_full;
    assign push_drop = ~bus.flush & push_only & is_full;
    assign pop_ok    = ~bus.flush & pop_only & ~is_empty;
    assign pop_drop  = ~bus.flush & pop_only & is_empty;

    assign wr_en  = push_ok | replace;
    assign wr_idx = replace ? top_idx : push_idx;

    stack_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (ret_addr),
        .raddr (top_idx),
        .rdata (top_data)
    );

    // Stack pointer: flush wins, then accepted push or pop; replace leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (bus.flush) begin
            sp_q <= '0;
        end else if (push_ok) begin
            sp_q <= sp_q + SW'(1);
        end else if (pop_ok) begin
            sp_q <= sp_q - SW'(1);
        end
    end

    // Sticky error flags: a new drop in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (pop_drop) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.from_stack = is_empty ? '0 : top_data;
    assign bus.sp         = sp_q;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack with hand-computed expectations.
// Latency: checks are sampled 1 time unit after the active edge.
// Backpressure: exercises dropped push (full) and dropped pop (empty).
module tb_return_stack;
    import rat_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    return_stack_if #(.DEPTH(16), .AW(10)) bus ();

    return_stack #(.DEPTH(16), .AW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one set of strobes for exactly one edge; returns 1 time unit after it.
    task automatic cyc(input logic p, input logic q, input logic f, input logic c,
                       input logic [9:0] pc);
        bus.push     = p;
        bus.pop      = q;
        bus.flush    = f;
        bus.clr_err  = c;
        bus.pc_count = pc;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_err  = 1'b0;
        bus.pc_count = '0;

        // Reset state
        #12;
        check("rst_sp",    32'(bus.sp), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full",  32'(bus.full), 0);
        check("rst_top",   32'(bus.from_stack), 0);
        check("rst_ovf",   32'(bus.overflow), 0);
        check("rst_unf",   32'(bus.underflow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First push right after release
        cyc(1, 0, 0, 0, 10'h010);
        check("push1_sp",    32'(bus.sp), 1);
        check("push1_top",   32'(bus.from_stack), 32'h011);
        check("push1_empty", 32'(bus.empty), 0);

        // Push two, pop twice from an empty stack
        cyc(0, 0, 1, 0, 10'h000);
        check("flush_sp", 32'(bus.sp), 0);
        cyc(1, 0, 0, 0, 10'h020);
        cyc(1, 0, 0, 0, 10'h030);
        check("pp_top2", 32'(bus.from_stack), 32'h031);
        check("pp_sp2",  32'(bus.sp), 2);
        cyc(0, 1, 0, 0, 10'h000);
        check("pop1_top", 32'(bus.from_stack), 32'h021);
        cyc(0, 1, 0, 0, 10'h000);
        check("pop2_empty", 32'(bus.empty), 1);
        check("pop2_top",   32'(bus.from_stack), 0);
        check("pop2_unf",   32'(bus.underflow), 0);

        // Return-address wrap
        cyc(1, 0, 0, 0, 10'h3FF);
        check("wrap_top", 32'(bus.from_stack), 0);
        check("wrap_sp",  32'(bus.sp), 1);
        cyc(0, 0, 1, 0, 10'h000);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 0, 10'(10'h040 + i));
        end
        check("fill_full", 32'(bus.full), 1);
        check("fill_sp",   32'(bus.sp), 16);
        check("fill_top",  32'(bus.from_stack), 32'h050);
        check("fill_ovf",  32'(bus.overflow), 0);
        cyc(1, 0, 0, 0, 10'h300);
        check("ovf_flag", 32'(bus.overflow), 1);
        check("ovf_sp",   32'(bus.sp), 16);
        check("ovf_top",  32'(bus.from_stack), 32'h050);
        cyc(0, 0, 0, 1, 10'h000);
        check("clr_ovf", 32'(bus.overflow), 0);
        // Drop and clear in the same cycle: the drop wins
        cyc(1, 0, 0, 1, 10'h300);
        check("ovf_vs_clr", 32'(bus.overflow), 1);
        cyc(0, 0, 0, 1, 10'h000);
        check("clr_ovf2", 32'(bus.overflow), 0);
        // Replace on a full stack is accepted
        cyc(1, 1, 0, 0, 10'h123);
        check("full_repl_top", 32'(bus.from_stack), 32'h124);
        check("full_repl_ovf", 32'(bus.overflow), 0);
        cyc(0, 0, 1, 0, 10'h000);

        // Underflow, then push+pop on empty acts as push
        cyc(0, 1, 0, 0, 10'h000);
        check("unf_flag", 32'(bus.underflow), 1);
        check("unf_sp",   32'(bus.sp), 0);
        cyc(1, 1, 0, 0, 10'h100);
        check("pp_empty_sp",  32'(bus.sp), 1);
        check("pp_empty_top", 32'(bus.from_stack), 32'h101);
        check("pp_empty_unf", 32'(bus.underflow), 1);
        cyc(0, 0, 0, 1, 10'h000);
        check("clr_unf", 32'(bus.underflow), 0);

        // Replace top at SP=3
        cyc(1, 0, 0, 0, 10'h110);
        cyc(1, 0, 0, 0, 10'h120);
        check("sp3", 32'(bus.sp), 3);
        cyc(1, 1, 0, 0, 10'h200);
        check("repl_sp",  32'(bus.sp), 3);
        check("repl_top", 32'(bus.from_stack), 32'h201);
        cyc(0, 1, 0, 0, 10'h000);
        check("repl_below", 32'(bus.from_stack), 32'h111);

        // Flush beats push
        cyc(1, 0, 1, 0, 10'h0AA);
        check("flush_push_sp",  32'(bus.sp), 0);
        check("flush_push_top", 32'(bus.from_stack), 0);

        // Asynchronous reset mid-cycle abandons an in-flight push
        cyc(1, 0, 0, 0, 10'h060);
        check("pre_rst_sp", 32'(bus.sp), 1);
        bus.push     = 1'b1;
        bus.pc_count = 10'h077;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sp",    32'(bus.sp), 0);
        check("arst_empty", 32'(bus.empty), 1);
        check("arst_top",   32'(bus.from_stack), 0);
        @(posedge clk);
        #1;
        check("arst_hold_sp", 32'(bus.sp), 0);
        bus.push = 1'b0;
        rst_n    = 1'b1;
        cyc(1, 0, 0, 0, 10'h050);
        check("post_rst_sp",  32'(bus.sp), 1);
        check("post_rst_top", 32'(bus.from_stack), 32'h051);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DEPTH, default 16, number of return-address entries; power of two, 4..64.
REQ-002 Parameter AW, default 10, return-address width; matches the program-counter width.
REQ-003 CLK  input  1  single rising-edge clock for all state.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 PC_COUNT  input  AW  current program-counter value.
REQ-006 PUSH  input  1  CALL strobe; save return address PC_COUNT+1.
REQ-007 POP  input  1  RET strobe; discard top entry.
REQ-008 FLUSH  input  1  synchronous clear of stack contents.
REQ-009 CLR_ERR  input  1  synchronous clear of sticky error flags.
REQ-010 FROM_STACK  output  AW  top-of-stack address; feeds the PC source mux.
REQ-011 SP  output  log2(DEPTH)+1  number of valid entries.
REQ-012 EMPTY  output  1  SP == 0.
REQ-013 FULL  output  1  SP == DEPTH.
REQ-014 OVERFLOW  output  1  sticky; a push was dropped.
REQ-015 UNDERFLOW  output  1  sticky; a pop was dropped.

Function
REQ-016 FROM_STACK SHALL combinationally equal entry[SP-1] when !EMPTY, and all zeros when EMPTY, so a RET can load the PC in the same cycle as its POP.
REQ-017 PUSH alone, !FULL: at the next edge, entry[SP] <= (PC_COUNT+1) mod 2^AW, and SP increments by 1.
REQ-018 Return-address arithmetic SHALL wrap: PC_COUNT = 2^AW-1 pushes 0.
REQ-019 POP alone, !EMPTY: SP decrements by 1 at the next edge; entry contents are not cleared.
REQ-020 PUSH and POP together, !EMPTY: entry[SP-1] <= PC_COUNT+1; SP is unchanged (replace top).
REQ-021 PUSH and POP together, EMPTY: treated as PUSH alone; UNDERFLOW is not set.
REQ-022 PUSH alone, FULL: the push is dropped, SP and entries are unchanged, and OVERFLOW <= 1.
REQ-023 POP alone, EMPTY: the pop is dropped, and UNDERFLOW <= 1.
REQ-024 FLUSH SHALL have priority over PUSH and POP: SP <= 0; entries and error flags are unchanged.
REQ-025 CLR_ERR clears OVERFLOW and UNDERFLOW at the next edge. An error event in the same cycle SHALL win: the flag is set.
REQ-026 EMPTY and FULL SHALL be decoded from the registered SP, with no extra latency.
REQ-027 Entry storage SHALL be written only on accepted pushes; there is no read port latency.

Reset
REQ-028 RST_N low SHALL immediately force SP = 0, OVERFLOW = 0 and UNDERFLOW = 0. Consequently EMPTY = 1, FULL = 0 and FROM_STACK = 0.
REQ-029 Entry storage is not reset; its contents are unobservable while EMPTY.
REQ-030 Reset asserted mid-operation SHALL abandon any in-flight push or pop; after release the stack is empty.
REQ-031 Reset release SHALL be synchronised externally; the first accepted edge after release may carry PUSH.

Structure
REQ-032 Shared package rat_pkg SHALL hold the PC width constant (PC_W = 10), the pc_t typedef, and the default stack depth constant; AW defaults to PC_W.
REQ-033 One sub-module, stack_regfile: DEPTH x AW storage with one synchronous write port and one asynchronous read port.
REQ-034 SP control, the error flags and the top-address computation SHALL reside in return_stack itself.

Verification
REQ-035 Reset, then PUSH with PC_COUNT=0x010 -> SP=1, FROM_STACK=0x011, EMPTY=0.
REQ-036 Push 0x020, 0x030, then POP twice -> FROM_STACK=0x031, then 0x021, then EMPTY=1 with FROM_STACK=0x000.
REQ-037 PUSH with PC_COUNT=0x3FF -> FROM_STACK=0x000.
REQ-038 Fill 16 entries, then PUSH -> FULL=1, SP=16, OVERFLOW=1, top unchanged. Then CLR_ERR -> OVERFLOW=0.
REQ-039 EMPTY, then POP -> UNDERFLOW=1. Then PUSH+POP with PC_COUNT=0x100 -> SP=1, FROM_STACK=0x101, UNDERFLOW stays 1.
REQ-040 SP=3, then PUSH+POP with PC_COUNT=0x200 -> SP=3, FROM_STACK=0x201. Then FLUSH+PUSH -> SP=0. Then RST_N low mid-cycle -> SP=0 immediately.
